// File: rtl/ddr2_bridge_pkg.sv
// Shared types for the data-cache to MIG DDR2 bridge: widths, MIG command codes, FSM states,
// and the queued request record.
package ddr2_bridge_pkg;
   localparam int ADDR_W = 27;
   localparam int DATA_W = 128;

   localparam logic [2:0] MIG_CMD_WR = 3'b000;
   localparam logic [2:0] MIG_CMD_RD = 3'b001;

   typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_e;

   typedef struct packed {
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;
endpackage

// File: rtl/ddr2_mig_bridge_if.sv
// MIG user-interface command, write-data and read-return signals.
// master = bridge side, slave = MIG controller side.
interface ddr2_mig_bridge_if;
   import ddr2_bridge_pkg::*;

   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en;
   logic              app_rdy;
   logic [DATA_W-1:0] app_wdf_data;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic              app_wdf_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid;

   modport master (
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );

   modport slave (
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );
endinterface

// File: rtl/ddr2_req_fifo.sv
// Synchronous request FIFO with combinational head; push is accepted when not full or when
// popping in the same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module ddr2_req_fifo
   import ddr2_bridge_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  req_t push_dat,
   input  logic pop,
   output req_t head,
   output logic full,
   output logic empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   req_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/ddr2_mig_bridge.sv
// Cache-to-MIG bridge: queues cache requests and issues them one at a time as MIG commands.
// Optional DDR2_BRIDGE_STATS_EN adds read/write/stall counters.
module ddr2_mig_bridge
   import ddr2_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ddr2_enable,
   input  logic              ddr2_read,
   input  logic [ADDR_W-1:0] ddr2_addr,
   input  logic [DATA_W-1:0] to_ddr2_data,
   output logic              ddr2_available,
   output logic [DATA_W-1:0] ddr2_data,
   output logic              err_overflow,
   input  logic              init_calib_complete,
   ddr2_mig_bridge_if.master mig
`ifdef DDR2_BRIDGE_STATS_EN
   ,
   output logic [31:0]       stat_rd_cnt,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              en_q, en_d;
   logic              wren_q, wren_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              avail_q, avail_d;
   logic              err_q, err_d;

   req_t push_req, head;
   logic full, empty, pop;

   assign push_req = '{rd: ddr2_read, addr: ddr2_addr, data: to_ddr2_data};

   ddr2_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (ddr2_enable),
      .push_dat (push_req),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      wdata_d = wdata_q;
      en_d    = en_q;
      wren_d  = wren_q;
      rdata_d = rdata_q;
      avail_d = 1'b0;
      pop     = 1'b0;
      err_d   = err_q | (ddr2_enable & full & ~pop);
      case (state_q)
         IDLE: begin
            if (!empty && init_calib_complete) begin
               pop    = 1'b1;
               addr_d = head.addr;
               en_d   = 1'b1;
               if (head.rd) begin
                  cmd_d   = MIG_CMD_RD;
                  state_d = RD;
               end else begin
                  cmd_d   = MIG_CMD_WR;
                  wdata_d = head.data;
                  wren_d  = 1'b1;
                  state_d = WR;
               end
            end
         end
         WR: begin
            // Command and data handshakes complete independently, in either order.
            if (mig.app_rdy)     en_d   = 1'b0;
            if (mig.app_wdf_rdy) wren_d = 1'b0;
            if (!en_d && !wren_d) state_d = IDLE;
         end
         RD: begin
            if (mig.app_rdy) begin
               en_d = 1'b0;
               if (mig.app_rd_data_valid) begin
                  rdata_d = mig.app_rd_data;
                  avail_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (mig.app_rd_data_valid) begin
               rdata_d = mig.app_rd_data;
               avail_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // err_d is recomputed after pop is known for this cycle.
      err_d = err_q | (ddr2_enable & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cmd_q   <= MIG_CMD_RD;
         wdata_q <= '0;
         en_q    <= 1'b0;
         wren_q  <= 1'b0;
         rdata_q <= '0;
         avail_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         en_q    <= en_d;
         wren_q  <= wren_d;
         rdata_q <= rdata_d;
         avail_q <= avail_d;
         err_q   <= err_d;
      end
   end

   assign mig.app_addr     = addr_q;
   assign mig.app_cmd      = cmd_q;
   assign mig.app_en       = en_q;
   assign mig.app_wdf_data = wdata_q;
   assign mig.app_wdf_wren = wren_q;
   assign mig.app_wdf_end  = wren_q;
   assign ddr2_available   = avail_q;
   assign ddr2_data        = rdata_q;
   assign err_overflow     = err_q;

`ifdef DDR2_BRIDGE_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (avail_d)                               rd_cnt_q    <= rd_cnt_q + 1'b1;
         if (state_q == WR && state_d == IDLE)      wr_cnt_q    <= wr_cnt_q + 1'b1;
         if (en_q && !mig.app_rdy)                  stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stat_rd_cnt    = rd_cnt_q;
   assign stat_wr_cnt    = wr_cnt_q;
   assign stat_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ddr2_mig_bridge.sv
// Directed bench for ddr2_mig_bridge: a small MIG responder driven per test and a posedge
// monitor that logs accepted commands, write-data beats, stalls and refill pulses.
module tb_ddr2_mig_bridge;
   import ddr2_bridge_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              ddr2_enable, ddr2_read;
   logic [ADDR_W-1:0] ddr2_addr;
   logic [DATA_W-1:0] to_ddr2_data;
   logic              ddr2_available;
   logic [DATA_W-1:0] ddr2_data;
   logic              err_overflow;
   logic              init_calib_complete;
`ifdef DDR2_BRIDGE_STATS_EN
   logic [31:0]       stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

   ddr2_mig_bridge_if mig ();

   ddr2_mig_bridge #(.FIFO_DEPTH(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ddr2_enable         (ddr2_enable),
      .ddr2_read           (ddr2_read),
      .ddr2_addr           (ddr2_addr),
      .to_ddr2_data        (to_ddr2_data),
      .ddr2_available      (ddr2_available),
      .ddr2_data           (ddr2_data),
      .err_overflow        (err_overflow),
      .init_calib_complete (init_calib_complete),
      .mig                 (mig)
`ifdef DDR2_BRIDGE_STATS_EN
      ,
      .stat_rd_cnt         (stat_rd_cnt),
      .stat_wr_cnt         (stat_wr_cnt),
      .stat_stall_cnt      (stat_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int n_wr_cmd = 0, n_rd_cmd = 0, n_wdf = 0, n_avail = 0, n_en_cyc = 0;
   int n_en_stall = 0, n_wdf_stall = 0;
   logic [2:0]        cmd_log [$];
   logic [ADDR_W-1:0] addr_log [$];
   logic [DATA_W-1:0] last_wdf;

   always @(posedge clk) begin
      if (!rst) begin
         if (mig.app_en) n_en_cyc++;
         if (mig.app_en && !mig.app_rdy) n_en_stall++;
         if (mig.app_wdf_wren && !mig.app_wdf_rdy) n_wdf_stall++;
         if (mig.app_en && mig.app_rdy) begin
            cmd_log.push_back(mig.app_cmd);
            addr_log.push_back(mig.app_addr);
            if (mig.app_cmd == 3'b000) n_wr_cmd++;
            else n_rd_cmd++;
         end
         if (mig.app_wdf_wren && mig.app_wdf_rdy) begin
            n_wdf++;
            last_wdf = mig.app_wdf_data;
         end
         if (ddr2_available) n_avail++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      ddr2_enable = 1'b1; ddr2_read = rd; ddr2_addr = a; to_ddr2_data = d;
      tick();
      ddr2_enable = 1'b0;
   endtask

   task automatic give_rd(input logic [DATA_W-1:0] d);
      mig.app_rd_data = d; mig.app_rd_data_valid = 1'b1;
      tick();
      mig.app_rd_data_valid = 1'b0;
   endtask

   task automatic wait_rd_cmd(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n_rd_cmd >= target) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_en(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (mig.app_en) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (mig.app_en !== 1'b0) begin bad++; $display("FAIL reset_app_en: got %b want 0", mig.app_en); end
      total++; if (mig.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", mig.app_wdf_wren); end
      total++; if (mig.app_wdf_end !== 1'b0) begin bad++; $display("FAIL reset_wdf_end: got %b want 0", mig.app_wdf_end); end
      total++; if (ddr2_available !== 1'b0) begin bad++; $display("FAIL reset_avail: got %b want 0", ddr2_available); end
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", err_overflow); end
      total++; if (mig.app_cmd !== 3'b001) begin bad++; $display("FAIL reset_cmd: got %b want 001", mig.app_cmd); end
      total++; if (mig.app_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", mig.app_addr); end
      total++; if (mig.app_wdf_data !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mig.app_wdf_data); end
      total++; if (ddr2_data !== '0) begin bad++; $display("FAIL reset_ddr2_data: got %h want 0", ddr2_data); end
   endtask

   task automatic test_read();
      logic [DATA_W-1:0] pat;
      int av0;
      pat = {16{8'hA5}};
      av0 = n_avail;
      push_req(1'b1, 27'h0001230, '0);
      total++; if (mig.app_en !== 1'b0) begin bad++; $display("FAIL rd_en_early: got %b want 0", mig.app_en); end
      tick();
      total++; if (mig.app_en !== 1'b1) begin bad++; $display("FAIL rd_en: got %b want 1", mig.app_en); end
      total++; if (mig.app_cmd !== 3'b001) begin bad++; $display("FAIL rd_cmd: got %b want 001", mig.app_cmd); end
      total++; if (mig.app_addr !== 27'h0001230) begin bad++; $display("FAIL rd_addr: got %h want 0001230", mig.app_addr); end
      repeat (10) tick();
      total++; if (ddr2_available !== 1'b0) begin bad++; $display("FAIL rd_avail_early: got %b want 0", ddr2_available); end
      give_rd(pat);
      total++; if (ddr2_available !== 1'b1) begin bad++; $display("FAIL rd_avail: got %b want 1", ddr2_available); end
      total++; if (ddr2_data !== pat) begin bad++; $display("FAIL rd_data: got %h want %h", ddr2_data, pat); end
      tick();
      total++; if (ddr2_available !== 1'b0) begin bad++; $display("FAIL rd_avail_pulse: got %b want 0", ddr2_available); end
      total++; if (ddr2_data !== pat) begin bad++; $display("FAIL rd_data_hold: got %h want %h", ddr2_data, pat); end
      total++; if (n_avail !== av0 + 1) begin bad++; $display("FAIL rd_avail_count: got %0d want %0d", n_avail, av0 + 1); end
   endtask

   task automatic test_back_to_back();
      int base, av0, wdf0;
      bit ok;
      logic [DATA_W-1:0] wpat, rpat;
      wpat = {16{8'h11}};
      rpat = {16{8'h22}};
      base = cmd_log.size(); av0 = n_avail; wdf0 = n_wdf;
      push_req(1'b0, 27'h0004560, wpat);
      push_req(1'b1, 27'h0008560, '0);
      wait_rd_cmd(n_rd_cmd + 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_rd_timeout: got no read cmd want 1"); end
      total++; if (cmd_log.size() !== base + 2) begin bad++; $display("FAIL b2b_ncmd: got %0d want %0d", cmd_log.size(), base + 2); end
      if (cmd_log.size() >= base + 2) begin
         total++; if (cmd_log[base] !== 3'b000 || addr_log[base] !== 27'h0004560) begin bad++; $display("FAIL b2b_first: got %b/%h want 000/0004560", cmd_log[base], addr_log[base]); end
         total++; if (cmd_log[base+1] !== 3'b001 || addr_log[base+1] !== 27'h0008560) begin bad++; $display("FAIL b2b_second: got %b/%h want 001/0008560", cmd_log[base+1], addr_log[base+1]); end
      end
      total++; if (n_wdf !== wdf0 + 1 || last_wdf !== wpat) begin bad++; $display("FAIL b2b_wdf: got %0d/%h want %0d/%h", n_wdf, last_wdf, wdf0 + 1, wpat); end
      total++; if (n_avail !== av0) begin bad++; $display("FAIL b2b_no_wr_avail: got %0d want %0d", n_avail, av0); end
      give_rd(rpat);
      total++; if (ddr2_available !== 1'b1 || ddr2_data !== rpat) begin bad++; $display("FAIL b2b_rd: got %b/%h want 1/%h", ddr2_available, ddr2_data, rpat); end
      repeat (5) tick();
      total++; if (n_avail !== av0 + 1) begin bad++; $display("FAIL b2b_avail_once: got %0d want %0d", n_avail, av0 + 1); end
   endtask

   task automatic test_stall();
      int wr0, wdf0, es0, ws0;
      bit ok;
      wr0 = n_wr_cmd; wdf0 = n_wdf; es0 = n_en_stall; ws0 = n_wdf_stall;
      mig.app_rdy = 1'b0; mig.app_wdf_rdy = 1'b0;
      push_req(1'b0, 27'h00077F0, {4{32'hCAFE_F00D}});
      wait_en(ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_en_timeout: got no app_en want 1"); end
      for (int i = 0; i < 8; i++) begin
         mig.app_rdy = (i >= 5);
         mig.app_wdf_rdy = (i >= 2);
         tick();
         if (i == 3) begin
            total++; if (mig.app_en !== 1'b1 || mig.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL stall_indep: got en=%b wren=%b want en=1 wren=0", mig.app_en, mig.app_wdf_wren); end
         end
      end
      total++; if (n_en_stall - es0 !== 5) begin bad++; $display("FAIL stall_en_cycles: got %0d want 5", n_en_stall - es0); end
      total++; if (n_wdf_stall - ws0 !== 2) begin bad++; $display("FAIL stall_wren_cycles: got %0d want 2", n_wdf_stall - ws0); end
      total++; if (n_wr_cmd !== wr0 + 1 || n_wdf !== wdf0 + 1) begin bad++; $display("FAIL stall_single_wr: got %0d/%0d want %0d/%0d", n_wr_cmd, n_wdf, wr0 + 1, wdf0 + 1); end
      total++; if (mig.app_en !== 1'b0) begin bad++; $display("FAIL stall_idle: got en=%b want 0", mig.app_en); end
   endtask

   task automatic test_overflow();
      int wr0, rd0, en0;
      bit ok;
      wr0 = n_wr_cmd; rd0 = n_rd_cmd;
      init_calib_complete = 1'b0;
      push_req(1'b0, 27'h0000100, {16{8'h5A}});
      push_req(1'b1, 27'h0000200, '0);
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
      push_req(1'b0, 27'h0000300, {16{8'h77}});
      total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", err_overflow); end
      en0 = n_en_cyc;
      repeat (5) tick();
      total++; if (n_en_cyc !== en0 || mig.app_en !== 1'b0) begin bad++; $display("FAIL ovf_no_cmd: got %0d en cycles want 0", n_en_cyc - en0); end
      init_calib_complete = 1'b1;
      wait_rd_cmd(rd0 + 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_rd_timeout: got no read cmd want 1"); end
      give_rd({16{8'h44}});
      repeat (10) tick();
      total++; if (n_wr_cmd !== wr0 + 1 || n_rd_cmd !== rd0 + 1) begin bad++; $display("FAIL ovf_two_cmds: got wr=%0d rd=%0d want wr=1 rd=1", n_wr_cmd - wr0, n_rd_cmd - rd0); end
      total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
   endtask

   task automatic test_reset_mid();
      int av0;
      bit ok;
      logic [DATA_W-1:0] pat;
      pat = {16{8'h33}};
      push_req(1'b1, 27'h0000550, '0);
      wait_rd_cmd(n_rd_cmd + 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: got no read cmd want 1"); end
      do_reset();
      total++; if (err_overflow !== 1'b0 || mig.app_en !== 1'b0) begin bad++; $display("FAIL rstmid_clear: got ovf=%b en=%b want 0/0", err_overflow, mig.app_en); end
      av0 = n_avail;
      give_rd({4{32'hDEAD_BEEF}});
      repeat (4) tick();
      total++; if (n_avail !== av0 || ddr2_data !== '0) begin bad++; $display("FAIL rstmid_stray: got avail=%0d data=%h want 0/0", n_avail - av0, ddr2_data); end
      push_req(1'b1, 27'h0000AB0, '0);
      wait_rd_cmd(n_rd_cmd + 1, ok);
      total++; if (!ok || addr_log[$] !== 27'h0000AB0) begin bad++; $display("FAIL rstmid_next_cmd: got ok=%b addr=%h want 1/0000ab0", ok, addr_log[$]); end
      give_rd(pat);
      total++; if (ddr2_available !== 1'b1 || ddr2_data !== pat) begin bad++; $display("FAIL rstmid_next_rd: got %b/%h want 1/%h", ddr2_available, ddr2_data, pat); end
   endtask

`ifdef DDR2_BRIDGE_STATS_EN
   task automatic test_stats();
      bit ok;
      do_reset();
      total++; if (stat_rd_cnt !== 0 || stat_wr_cnt !== 0 || stat_stall_cnt !== 0) begin bad++; $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_rd_cnt, stat_wr_cnt, stat_stall_cnt); end
      for (int i = 0; i < 3; i++) begin
         push_req(1'b0, 27'(32'h1000 + 32'(i) * 32'h10), {4{32'(i)}});
         repeat (3) tick();
      end
      mig.app_rdy = 1'b0;
      push_req(1'b1, 27'h0002000, '0);
      wait_en(ok);
      total++; if (!ok) begin bad++; $display("FAIL stats_en_timeout: got no app_en want 1"); end
      repeat (4) tick();
      mig.app_rdy = 1'b1;
      wait_rd_cmd(n_rd_cmd + 1, ok);
      give_rd({16{8'h66}});
      push_req(1'b1, 27'h0002010, '0);
      wait_rd_cmd(n_rd_cmd + 1, ok);
      give_rd({16{8'h67}});
      repeat (3) tick();
      total++; if (stat_wr_cnt !== 3) begin bad++; $display("FAIL stats_wr: got %0d want 3", stat_wr_cnt); end
      total++; if (stat_rd_cnt !== 2) begin bad++; $display("FAIL stats_rd: got %0d want 2", stat_rd_cnt); end
      total++; if (stat_stall_cnt !== 4) begin bad++; $display("FAIL stats_stall: got %0d want 4", stat_stall_cnt); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      ddr2_enable = 1'b0; ddr2_read = 1'b0; ddr2_addr = '0; to_ddr2_data = '0;
      init_calib_complete = 1'b1;
      mig.app_rdy = 1'b1; mig.app_wdf_rdy = 1'b1;
      mig.app_rd_data = '0; mig.app_rd_data_valid = 1'b0;
      test_reset();
      test_read();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_reset_mid();
`ifdef DDR2_BRIDGE_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
